// File: rtl/cpu_wb_pkg.sv
// Shared write-back definitions: FSM state encoding, link register and the
// opcodes the control unit also decodes.
package cpu_wb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitMem,
        StCommit
    } wb_state_e;

    localparam logic [4:0] REG_RA = 5'd31;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_JAL = 6'b000011;

    // JAL always links into $ra; otherwise R-type writes rd, I-type writes rt.
    function automatic logic [4:0] wb_dest(input logic       jal,
                                           input logic       regdst,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
        if (jal) begin
            return REG_RA;
        end else if (regdst) begin
            return rd;
        end
        return rt;
    endfunction

endpackage

// File: rtl/writeback_ctrl_if.sv
// Request, memory-return and register-file write bundle for writeback_ctrl.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface writeback_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic        req_regwrite;
    logic        req_memtoreg;
    logic        req_regdst;
    logic        req_jal;
    logic [31:0] req_alu_result;
    logic [31:0] req_pc_plus4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_err;
    logic        busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        fwd_rs_hit;
    logic        fwd_rt_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;

    modport slave (
        input  req_valid, req_instr, req_regwrite, req_memtoreg, req_regdst, req_jal,
        input  req_alu_result, req_pc_plus4, mem_rvalid, mem_rdata, rs_addr, rt_addr,
        output req_ready, wb_we, wb_addr, wb_data, wb_err, busy,
        output fwd_rs_hit, fwd_rt_hit, fwd_data, fwd_stall
    );

    modport master (
        output req_valid, req_instr, req_regwrite, req_memtoreg, req_regdst, req_jal,
        output req_alu_result, req_pc_plus4, mem_rvalid, mem_rdata, rs_addr, rt_addr,
        input  req_ready, wb_we, wb_addr, wb_data, wb_err, busy,
        input  fwd_rs_hit, fwd_rt_hit, fwd_data, fwd_stall
    );
`else
    modport slave (
        input  req_valid, req_instr, req_regwrite, req_memtoreg, req_regdst, req_jal,
        input  req_alu_result, req_pc_plus4, mem_rvalid, mem_rdata,
        output req_ready, wb_we, wb_addr, wb_data, wb_err, busy
    );

    modport master (
        output req_valid, req_instr, req_regwrite, req_memtoreg, req_regdst, req_jal,
        output req_alu_result, req_pc_plus4, mem_rvalid, mem_rdata,
        input  req_ready, wb_we, wb_addr, wb_data, wb_err, busy
    );
`endif

endinterface

// File: rtl/wb_fwd_cmp.sv
// Decoder-operand comparators against the pending write-back: forward when the
// write is committing, stall when it is still waiting on data memory.
module wb_fwd_cmp
    import cpu_wb_pkg::*;
(
    input  wb_state_e   state,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        fwd_rs_hit,
    output logic        fwd_rt_hit,
    output logic [31:0] fwd_data,
    output logic        fwd_stall
);

    logic rs_match;
    logic rt_match;

    assign rs_match   = (rs_addr == wb_addr) && (wb_addr != 5'd0);
    assign rt_match   = (rt_addr == wb_addr) && (wb_addr != 5'd0);

    assign fwd_rs_hit = (state == StCommit) && rs_match;
    assign fwd_rt_hit = (state == StCommit) && rt_match;
    assign fwd_data   = (state == StCommit) ? wb_data : 32'd0;
    assign fwd_stall  = (state == StWaitMem) && (rs_match || rt_match);

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write-back controller: accepts retiring instructions, waits for
// load data with a timeout and issues one registered write. Option: WB_BYPASS_EN.
module writeback_ctrl
    import cpu_wb_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic             clock,
    input logic             reset,
    writeback_ctrl_if.slave bus
);

    wb_state_e   state_q;
    logic [7:0]  cnt_q;
    logic        wb_we_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic        wb_err_q;

    logic        accept;
    logic [4:0]  dest;
    logic        unused_instr;

    assign bus.req_ready = (state_q == StIdle) || (state_q == StCommit);
    assign accept        = bus.req_valid && bus.req_ready;
    assign dest          = wb_dest(bus.req_jal, bus.req_regdst,
                                   bus.req_instr[20:16], bus.req_instr[15:11]);
    assign unused_instr  = ^{bus.req_instr[31:21], bus.req_instr[10:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'd0;
            wb_err_q  <= 1'b0;
        end else begin
            wb_we_q  <= 1'b0;
            wb_err_q <= 1'b0;
            unique case (state_q)
                // COMMIT accepts like IDLE so ALU writes can retire every cycle.
                StIdle, StCommit: begin
                    state_q <= StIdle;
                    if (accept && bus.req_regwrite && (dest != 5'd0)) begin
                        wb_addr_q <= dest;
                        if (bus.req_memtoreg) begin
                            cnt_q   <= 8'd0;
                            state_q <= StWaitMem;
                        end else begin
                            wb_data_q <= bus.req_jal ? bus.req_pc_plus4 : bus.req_alu_result;
                            wb_we_q   <= 1'b1;
                            state_q   <= StCommit;
                        end
                    end
                end
                StWaitMem: begin
                    // Data arriving on the expiry cycle still commits.
                    if (bus.mem_rvalid) begin
                        wb_data_q <= bus.mem_rdata;
                        wb_we_q   <= 1'b1;
                        state_q   <= StCommit;
                    end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
                        wb_err_q <= 1'b1;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.wb_we   = wb_we_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;
    assign bus.wb_err  = wb_err_q;
    assign bus.busy    = (state_q != StIdle);

`ifdef WB_BYPASS_EN
    wb_fwd_cmp u_fwd_cmp (
        .state      (state_q),
        .wb_addr    (wb_addr_q),
        .wb_data    (wb_data_q),
        .rs_addr    (bus.rs_addr),
        .rt_addr    (bus.rt_addr),
        .fwd_rs_hit (bus.fwd_rs_hit),
        .fwd_rt_hit (bus.fwd_rt_hit),
        .fwd_data   (bus.fwd_data),
        .fwd_stall  (bus.fwd_stall)
    );
`endif

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl with MEM_TIMEOUT = 4.
module tb_writeback_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    writeback_ctrl_if bus ();

    writeback_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_instr(input logic [4:0] rt, input logic [4:0] rd);
        return {6'b100011, 5'd3, rt, rd, 11'h2a5};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic [4:0] rt, input logic [4:0] rd, input logic regwrite,
                             input logic memtoreg, input logic regdst, input logic jal,
                             input logic [31:0] alu, input logic [31:0] pc4);
        bus.req_valid      = 1'b1;
        bus.req_instr      = mk_instr(rt, rd);
        bus.req_regwrite   = regwrite;
        bus.req_memtoreg   = memtoreg;
        bus.req_regdst     = regdst;
        bus.req_jal        = jal;
        bus.req_alu_result = alu;
        bus.req_pc_plus4   = pc4;
    endtask

    task automatic idle_req();
        bus.req_valid    = 1'b0;
        bus.req_regwrite = 1'b0;
        bus.req_memtoreg = 1'b0;
        bus.req_regdst   = 1'b0;
        bus.req_jal      = 1'b0;
        bus.mem_rvalid   = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] obs;
        obs = {bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_err, bus.busy, bus.req_ready};
        checks++;
        if (obs !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", obs, {1'b0, 5'd0, 32'd0, 3'b001});
        end
    endtask

    task automatic test_alu_back_to_back();
        drive_req(5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0);
        step();
        checks++;
        if ({bus.wb_we, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd5, 32'h0000_1234}) begin
            errors++;
            $display("FAIL alu_write: got we=%b addr=%0d data=%h want 1/5/00001234",
                     bus.wb_we, bus.wb_addr, bus.wb_data);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_commit: got %b want 1", bus.req_ready);
        end
        drive_req(5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_5678, 32'h0);
        step();
        idle_req();
        checks++;
        if ({bus.wb_we, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd6, 32'h0000_5678}) begin
            errors++;
            $display("FAIL b2b_write: got we=%b addr=%0d data=%h want 1/6/00005678",
                     bus.wb_we, bus.wb_addr, bus.wb_data);
        end
        step();
        checks++;
        if ({bus.wb_we, bus.busy, bus.wb_addr, bus.wb_data} !== {2'b00, 5'd6, 32'h0000_5678}) begin
            errors++;
            $display("FAIL hold_after_commit: got we=%b busy=%b addr=%0d data=%h want 0/0/6/00005678",
                     bus.wb_we, bus.busy, bus.wb_addr, bus.wb_data);
        end
    endtask

    task automatic test_jal();
        drive_req(5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 32'hdead_beef, 32'h0040_0008);
        step();
        idle_req();
        checks++;
        if ({bus.wb_we, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd31, 32'h0040_0008}) begin
            errors++;
            $display("FAIL jal_link: got we=%b addr=%0d data=%h want 1/31/00400008",
                     bus.wb_we, bus.wb_addr, bus.wb_data);
        end
        step();
        drive_req(5'd4, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'hdead_beef, 32'h0040_0008);
        step();
        idle_req();
        checks++;
        if ({bus.busy, bus.req_ready, bus.wb_we} !== 3'b100) begin
            errors++;
            $display("FAIL jal_mem_wait: got busy/ready/we=%b want 100",
                     {bus.busy, bus.req_ready, bus.wb_we});
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.wb_we, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd31, 32'h1111_2222}) begin
            errors++;
            $display("FAIL jal_memtoreg: got we=%b addr=%0d data=%h want 1/31/11112222",
                     bus.wb_we, bus.wb_addr, bus.wb_data);
        end
        step();
    endtask

    task automatic test_load();
        int we_seen = 0;
        drive_req(5'd9, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0bad_0bad, 32'h0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hffff_0000;
        step();
        idle_req();
        checks++;
        if ({bus.busy, bus.req_ready, bus.wb_we} !== 3'b100) begin
            errors++;
            $display("FAIL load_wait_entry: got busy/ready/we=%b want 100",
                     {bus.busy, bus.req_ready, bus.wb_we});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.wb_we === 1'b1 || bus.req_ready !== 1'b0) we_seen++;
        end
        checks++;
        if (we_seen != 0) begin
            errors++;
            $display("FAIL load_still_waiting: got %0d bad cycles want 0", we_seen);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hcafe_f00d;
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.wb_we, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd9, 32'hcafe_f00d}) begin
            errors++;
            $display("FAIL load_commit: got we=%b addr=%0d data=%h want 1/9/cafef00d",
                     bus.wb_we, bus.wb_addr, bus.wb_data);
        end
        step();
    endtask

    task automatic test_timeout();
        int errs = 0;
        int wes  = 0;
        drive_req(5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        idle_req();
        for (int i = 1; i <= 6; i++) begin
            step();
            if (bus.wb_err === 1'b1) errs++;
            if (bus.wb_we === 1'b1) wes++;
            if (i == 4) begin
                checks++;
                if ({bus.wb_err, bus.busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL timeout_edge: got err/busy=%b want 10", {bus.wb_err, bus.busy});
                end
            end
        end
        checks++;
        if (errs != 1 || wes != 0) begin
            errors++;
            $display("FAIL timeout_counts: got err=%0d we=%0d want 1/0", errs, wes);
        end
    endtask

    task automatic test_timeout_race();
        drive_req(5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        idle_req();
        step();
        step();
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0123_4567;
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.wb_we, bus.wb_err, bus.wb_addr, bus.wb_data} !== {2'b10, 5'd8, 32'h0123_4567}) begin
            errors++;
            $display("FAIL timeout_race: got we=%b err=%b addr=%0d data=%h want 1/0/8/01234567",
                     bus.wb_we, bus.wb_err, bus.wb_addr, bus.wb_data);
        end
        step();
    endtask

    task automatic test_no_write();
        int bad = 0;
        drive_req(5'd3, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0);
        step();
        if (bus.wb_we === 1'b1 || bus.busy === 1'b1) bad++;
        drive_req(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h66, 32'h0);
        step();
        if (bus.wb_we === 1'b1 || bus.busy === 1'b1) bad++;
        drive_req(5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0);
        step();
        if (bus.wb_we === 1'b1 || bus.busy === 1'b1) bad++;
        idle_req();
        step();
        if (bus.wb_we === 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_write_cases: got %0d write/busy cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid_load();
        int wes = 0;
        drive_req(5'd10, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        idle_req();
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_err, bus.busy, bus.req_ready}
                !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_load: got addr=%0d busy=%b ready=%b want 0/0/1",
                     bus.wb_addr, bus.busy, bus.req_ready);
        end
        step();
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hbeef_0001;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.wb_we === 1'b1 || bus.busy === 1'b1) wes++;
        end
        bus.mem_rvalid = 1'b0;
        checks++;
        if (wes != 0 || bus.wb_addr !== 5'd0) begin
            errors++;
            $display("FAIL late_rvalid: got bad=%0d addr=%0d want 0/0", wes, bus.wb_addr);
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd3;
        drive_req(5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_abcd, 32'h0);
        step();
        idle_req();
        checks++;
        if ({bus.fwd_rs_hit, bus.fwd_rt_hit, bus.fwd_stall, bus.fwd_data} !== {3'b100, 32'h0000_abcd}) begin
            errors++;
            $display("FAIL fwd_commit: got rs/rt/stall=%b data=%h want 100/0000abcd",
                     {bus.fwd_rs_hit, bus.fwd_rt_hit, bus.fwd_stall}, bus.fwd_data);
        end
        bus.rs_addr = 5'd1;
        bus.rt_addr = 5'd9;
        drive_req(5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        idle_req();
        checks++;
        if ({bus.fwd_rs_hit, bus.fwd_rt_hit, bus.fwd_stall} !== 3'b001) begin
            errors++;
            $display("FAIL fwd_stall: got rs/rt/stall=%b want 001",
                     {bus.fwd_rs_hit, bus.fwd_rt_hit, bus.fwd_stall});
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h9;
        step();
        bus.mem_rvalid = 1'b0;
        step();
    endtask
`endif

    initial begin
        bus.req_instr      = 32'h0;
        bus.req_alu_result = 32'h0;
        bus.req_pc_plus4   = 32'h0;
        bus.mem_rdata      = 32'h0;
`ifdef WB_BYPASS_EN
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;
`endif
        idle_req();
        #12;
        test_reset();
        step();
        reset = 1'b0;
        step();
        test_alu_back_to_back();
        test_jal();
        test_load();
        test_timeout();
        test_timeout_race();
        test_no_write();
        test_reset_mid_load();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
